// File: rtl/uart_baud_gen_frac.sv
// Purpose     : fractional-N UART tick generator (rx_tick at baud*OSR, tx_tick at baud) with runtime divisor load and phase resync.
// Latency     : first rx_tick P = max(div,2)+carry clocks after restart; all outputs registered, no input-to-output comb path.
// Backpressure: none; en_i=0 freezes the phase and forces ticks low, while strobes are always honoured.
//
// Ports
//   clk_i        system clock, all logic on posedge
//   rst_i        asynchronous active-high reset
//   en_i         1 = count, 0 = hold cnt/acc/carry/os_cnt and suppress ticks
//   div_load_i   1-cycle strobe: latch div_int_i/div_frac_i and restart the phase
//   div_int_i    integer divisor (clk cycles per rx_tick); 0 and 1 behave as 2
//   div_frac_i   fractional divisor in units of 1/2**FRAC_W clock
//   resync_i     1-cycle strobe: restart the phase, keep the divisor
//   rx_tick_o    oversample tick, 1-cycle pulse
//   tx_tick_o    baud tick, only ever together with the OSR-th rx_tick
//   os_phase_o   current oversample slot 0..OSR-1
module uart_baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OSR          = 16,
    parameter int DEFAULT_INT  = 65,
    parameter int DEFAULT_FRAC = 2,
    localparam int PH_W        = $clog2(OSR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              div_load_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    input  logic              resync_i,
    output logic              rx_tick_o,
    output logic              tx_tick_o,
    output logic [PH_W-1:0]   os_phase_o
);

    // Stored divisor (raw, unclamped) and phase state.
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [FRAC_W-1:0] frac_q,    frac_d;
    logic [DIV_W-1:0]  cnt_q,     cnt_d;
    logic [FRAC_W-1:0] acc_q,     acc_d;
    logic              carry_q,   carry_d;
    logic [PH_W-1:0]   os_cnt_q,  os_cnt_d;
    logic              rx_tick_q, rx_tick_d;
    logic              tx_tick_q, tx_tick_d;

    // Derived per-period values.
    logic [DIV_W-1:0]  div_eff;
    logic [DIV_W:0]    period_m1;
    logic              at_end;
    logic [FRAC_W:0]   frac_sum;
    logic              os_last;

    // A divisor of 0 or 1 cannot produce a distinct tick per period, so the
    // counter always runs at least two cycles.
    assign div_eff = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;

    // P-1 is formed one bit wider so that div_eff = 2**DIV_W-1 plus a carry
    // still compares correctly; div_eff >= 2 keeps the subtraction positive.
    assign period_m1 = {1'b0, div_eff}
                     + {{DIV_W{1'b0}}, carry_q}
                     - {{DIV_W{1'b0}}, 1'b1};

    assign at_end = ({1'b0, cnt_q} == period_m1);

    // Fractional accumulator: its carry out stretches the NEXT period by one
    // clock, which spreads the remainder evenly across rx_ticks.
    assign frac_sum = {1'b0, acc_q} + {1'b0, frac_q};

    assign os_last = (os_cnt_q == PH_W'(OSR - 1));

    always_comb begin
        div_d     = div_q;
        frac_d    = frac_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        os_cnt_d  = os_cnt_q;
        rx_tick_d = 1'b0;
        tx_tick_d = 1'b0;

        if (div_load_i || resync_i) begin
            // Either strobe restarts the phase grid and swallows any tick
            // that would have fired this cycle; div_load also takes the new
            // divisor, so it covers the case where both strobes coincide.
            if (div_load_i) begin
                div_d  = div_int_i;
                frac_d = div_frac_i;
            end
            cnt_d    = '0;
            acc_d    = '0;
            carry_d  = 1'b0;
            os_cnt_d = '0;
        end else if (en_i) begin
            if (at_end) begin
                cnt_d              = '0;
                rx_tick_d          = 1'b1;
                {carry_d, acc_d}   = frac_sum;
                tx_tick_d          = os_last;
                os_cnt_d           = os_last ? '0 : os_cnt_q + PH_W'(1);
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q     <= DIV_W'(DEFAULT_INT);
            frac_q    <= FRAC_W'(DEFAULT_FRAC);
            cnt_q     <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            os_cnt_q  <= '0;
            rx_tick_q <= 1'b0;
            tx_tick_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            frac_q    <= frac_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            os_cnt_q  <= os_cnt_d;
            rx_tick_q <= rx_tick_d;
            tx_tick_q <= tx_tick_d;
        end
    end

    assign rx_tick_o  = rx_tick_q;
    assign tx_tick_o  = tx_tick_q;
    assign os_phase_o = os_cnt_q;

endmodule
